// File: rtl/iomem_initiator_arbiter.sv
// ---------------------------------------------------------------------------
// iomem_initiator_arbiter
//
// Initiator side of the iomem valid/ready bus. Two requesters share the bus:
// an instruction-fetch port (i_*) and a data load/store port (d_*). One
// transaction is in flight at a time. The response (read data or a timeout
// error) goes back only to the port that issued the request.
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | no transaction; requests are granted combinationally
// BUS   | transaction driven on iomem, waiting for ready or timeout
// RESP  | one-cycle response pulse to the owning port
//
// Ports
//   clk_i, rst_n           clock, synchronous active-low reset
//   i_req_valid_i/ready_o  fetch request handshake, i_addr_i byte address
//   i_rsp_valid_o/rdata_o/err_o  fetch response (1-cycle pulse)
//   d_req_valid_i/ready_o  data request handshake, d_addr_i/d_wdata_i/d_wstrb_i
//   d_rsp_valid_o/rdata_o/err_o  data response (1-cycle pulse)
//   iomem_*                bus request/response signals
//   busy_o                 high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module iomem_initiator_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = 7
) (
    input  logic        clk_i,
    input  logic        rst_n,

    input  logic        i_req_valid_i,
    output logic        i_req_ready_o,
    input  logic [31:0] i_addr_i,
    output logic        i_rsp_valid_o,
    output logic [31:0] i_rsp_rdata_o,
    output logic        i_rsp_err_o,

    input  logic        d_req_valid_i,
    output logic        d_req_ready_o,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_wstrb_i,
    output logic        d_rsp_valid_o,
    output logic [31:0] d_rsp_rdata_o,
    output logic        d_rsp_err_o,

    output logic        iomem_valid_o,
    input  logic        iomem_ready_i,
    output logic [31:0] iomem_addr_o,
    output logic [31:0] iomem_wdata_o,
    output logic [3:0]  iomem_wstrb_o,
    input  logic [31:0] iomem_rdata_i,

    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q;
    logic              last_gnt_data_q;   // 1: data port won the most recent grant
    logic              owner_data_q;      // 1: in-flight transaction belongs to data port
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic              iomem_valid_q;
    logic              busy_q;

    logic              i_rsp_valid_q;
    logic [31:0]       i_rsp_rdata_q;
    logic              i_rsp_err_q;
    logic              d_rsp_valid_q;
    logic [31:0]       d_rsp_rdata_q;
    logic              d_rsp_err_q;

    logic              gnt_i;
    logic              gnt_d;
    logic              bus_done;
    logic [31:0]       bus_rdata_d;
    logic              bus_err_d;
    logic [31:0]       i_addr_word;
    logic [31:0]       d_addr_word;

    // The bus is word addressed; byte offset bits are dropped.
    logic              unused_addr_lsb;
    assign unused_addr_lsb = ^{i_addr_i[1:0], d_addr_i[1:0]};

    assign i_addr_word = {i_addr_i[31:2], 2'b00};
    assign d_addr_word = {d_addr_i[31:2], 2'b00};

    // Round-robin grant, only offered in IDLE. A tie goes to the port that
    // did not win last time. Gated with rst_n so no requester sees an
    // acceptance while reset is being applied.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (rst_n && (state_q == S_IDLE)) begin
            if (i_req_valid_i && d_req_valid_i) begin
                gnt_d = ~last_gnt_data_q;
                gnt_i =  last_gnt_data_q;
            end else begin
                gnt_i = i_req_valid_i;
                gnt_d = d_req_valid_i;
            end
        end
    end

    assign i_req_ready_o = gnt_i;
    assign d_req_ready_o = gnt_d;

    // Ready wins over a timeout landing on the same cycle.
    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        bus_done    = iomem_ready_i || (cnt_q == CNT_LAST);
        bus_rdata_d = iomem_ready_i ? iomem_rdata_i : 32'h0;
        bus_err_d   = ~iomem_ready_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            last_gnt_data_q <= 1'b0;
            owner_data_q    <= 1'b0;
            cnt_q           <= '0;
            addr_q          <= 32'h0;
            wdata_q         <= 32'h0;
            wstrb_q         <= 4'h0;
            iomem_valid_q   <= 1'b0;
            busy_q          <= 1'b0;
            i_rsp_valid_q   <= 1'b0;
            i_rsp_rdata_q   <= 32'h0;
            i_rsp_err_q     <= 1'b0;
            d_rsp_valid_q   <= 1'b0;
            d_rsp_rdata_q   <= 32'h0;
            d_rsp_err_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_i || gnt_d) begin
                        owner_data_q    <= gnt_d;
                        last_gnt_data_q <= gnt_d;
                        addr_q          <= gnt_d ? d_addr_word : i_addr_word;
                        // Fetches never write.
                        wdata_q         <= gnt_d ? d_wdata_i : 32'h0;
                        wstrb_q         <= gnt_d ? d_wstrb_i : 4'h0;
                        cnt_q           <= '0;
                        iomem_valid_q   <= 1'b1;
                        busy_q          <= 1'b1;
                        state_q         <= S_BUS;
                    end
                end

                S_BUS: begin
                    if (bus_done) begin
                        iomem_valid_q <= 1'b0;
                        state_q       <= S_RESP;
                        if (owner_data_q) begin
                            d_rsp_valid_q <= 1'b1;
                            d_rsp_rdata_q <= bus_rdata_d;
                            d_rsp_err_q   <= bus_err_d;
                        end else begin
                            i_rsp_valid_q <= 1'b1;
                            i_rsp_rdata_q <= bus_rdata_d;
                            i_rsp_err_q   <= bus_err_d;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end

                S_RESP: begin
                    // Response outputs are zero outside their one-cycle pulse.
                    i_rsp_valid_q <= 1'b0;
                    i_rsp_rdata_q <= 32'h0;
                    i_rsp_err_q   <= 1'b0;
                    d_rsp_valid_q <= 1'b0;
                    d_rsp_rdata_q <= 32'h0;
                    d_rsp_err_q   <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end

                default: begin
                    iomem_valid_q <= 1'b0;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end
            endcase
        end
    end

    assign iomem_valid_o = iomem_valid_q;
    assign iomem_addr_o  = addr_q;
    assign iomem_wdata_o = wdata_q;
    assign iomem_wstrb_o = wstrb_q;
    assign busy_o        = busy_q;

    assign i_rsp_valid_o = i_rsp_valid_q;
    assign i_rsp_rdata_o = i_rsp_rdata_q;
    assign i_rsp_err_o   = i_rsp_err_q;
    assign d_rsp_valid_o = d_rsp_valid_q;
    assign d_rsp_rdata_o = d_rsp_rdata_q;
    assign d_rsp_err_o   = d_rsp_err_q;

endmodule

// File: tb/tb_iomem_initiator_arbiter.sv
`timescale 1ns/1ps
module tb_iomem_initiator_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_req_valid_i = 1'b0;
    logic        i_req_ready_o;
    logic [31:0] i_addr_i = 32'h0;
    logic        i_rsp_valid_o;
    logic [31:0] i_rsp_rdata_o;
    logic        i_rsp_err_o;
    logic        d_req_valid_i = 1'b0;
    logic        d_req_ready_o;
    logic [31:0] d_addr_i = 32'h0;
    logic [31:0] d_wdata_i = 32'h0;
    logic [3:0]  d_wstrb_i = 4'h0;
    logic        d_rsp_valid_o;
    logic [31:0] d_rsp_rdata_o;
    logic        d_rsp_err_o;
    logic        iomem_valid_o;
    logic        iomem_ready_i = 1'b0;
    logic [31:0] iomem_addr_o;
    logic [31:0] iomem_wdata_o;
    logic [3:0]  iomem_wstrb_o;
    logic [31:0] iomem_rdata_i = 32'h0;
    logic        busy_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk_i = ~clk_i;

    iomem_initiator_arbiter #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .i_req_valid_i (i_req_valid_i),
        .i_req_ready_o (i_req_ready_o),
        .i_addr_i      (i_addr_i),
        .i_rsp_valid_o (i_rsp_valid_o),
        .i_rsp_rdata_o (i_rsp_rdata_o),
        .i_rsp_err_o   (i_rsp_err_o),
        .d_req_valid_i (d_req_valid_i),
        .d_req_ready_o (d_req_ready_o),
        .d_addr_i      (d_addr_i),
        .d_wdata_i     (d_wdata_i),
        .d_wstrb_i     (d_wstrb_i),
        .d_rsp_valid_o (d_rsp_valid_o),
        .d_rsp_rdata_o (d_rsp_rdata_o),
        .d_rsp_err_o   (d_rsp_err_o),
        .iomem_valid_o (iomem_valid_o),
        .iomem_ready_i (iomem_ready_i),
        .iomem_addr_o  (iomem_addr_o),
        .iomem_wdata_o (iomem_wdata_o),
        .iomem_wstrb_o (iomem_wstrb_o),
        .iomem_rdata_i (iomem_rdata_i),
        .busy_o        (busy_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          is_data;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          delay;      // BUS cycles with ready low before the ready cycle; -1 = never
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        int          exp_vcyc;   // cycles iomem_valid_o is high
        bit          chk_rdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    // One complete transaction on a single port, responder driven by the bench.
    task automatic do_txn(input vec_t v, input string tag);
        int          vcyc;
        int          lat;
        bit          stable;
        bit          got;
        logic        own_valid, oth_valid, oth_err;
        logic [31:0] own_rdata, oth_rdata;
        logic        own_err;
        vcyc = 0; lat = -1; stable = 1'b1; got = 1'b0;
        own_valid = 1'b0; oth_valid = 1'b0; oth_err = 1'b0;
        own_rdata = 32'h0; oth_rdata = 32'h0; own_err = 1'b0;

        @(negedge clk_i);
        if (v.is_data) begin
            d_req_valid_i = 1'b1; d_addr_i = v.addr; d_wdata_i = v.wdata; d_wstrb_i = v.wstrb;
        end else begin
            i_req_valid_i = 1'b1; i_addr_i = v.addr;
        end
        #1;
        check({tag, ".req_ready{i,d}"}, {30'b0, i_req_ready_o, d_req_ready_o},
              v.is_data ? 32'd1 : 32'd2);
        @(posedge clk_i); #1;
        i_req_valid_i = 1'b0; d_req_valid_i = 1'b0;
        i_addr_i = 32'hFFFF_FFFF; d_addr_i = 32'hFFFF_FFFF;
        d_wdata_i = 32'hBAD0_BAD0; d_wstrb_i = 4'hF;

        for (int c = 0; c < 200 && !got; c++) begin
            @(negedge clk_i);
            iomem_ready_i = 1'b0;
            iomem_rdata_i = $urandom | 32'h1;
            if (i_rsp_valid_o || d_rsp_valid_o) begin
                got = 1'b1;
                lat = c;
                own_valid = v.is_data ? d_rsp_valid_o : i_rsp_valid_o;
                own_rdata = v.is_data ? d_rsp_rdata_o : i_rsp_rdata_o;
                own_err   = v.is_data ? d_rsp_err_o   : i_rsp_err_o;
                oth_valid = v.is_data ? i_rsp_valid_o : d_rsp_valid_o;
                oth_rdata = v.is_data ? i_rsp_rdata_o : d_rsp_rdata_o;
                oth_err   = v.is_data ? i_rsp_err_o   : d_rsp_err_o;
                check({tag, ".valid_in_resp"}, {31'b0, iomem_valid_o}, 32'd0);
            end else begin
                if (iomem_valid_o) begin
                    vcyc++;
                    if (iomem_addr_o !== v.exp_addr || iomem_wdata_o !== v.exp_wdata ||
                        iomem_wstrb_o !== v.exp_wstrb)
                        stable = 1'b0;
                end
                if (c == v.delay) begin
                    iomem_ready_i = 1'b1;
                    iomem_rdata_i = v.rdata;
                end
            end
        end

        check({tag, ".rsp_seen"}, {31'b0, got}, 32'd1);
        check({tag, ".bus_fields_stable"}, {31'b0, stable}, 32'd1);
        check({tag, ".valid_cycles"}, vcyc, v.exp_vcyc);
        check({tag, ".rsp_latency"}, lat, v.exp_vcyc);
        check({tag, ".own_rsp_valid"}, {31'b0, own_valid}, 32'd1);
        check({tag, ".own_rsp_err"}, {31'b0, own_err}, {31'b0, v.exp_err});
        if (v.chk_rdata) check({tag, ".own_rsp_rdata"}, own_rdata, v.exp_rdata);
        check({tag, ".other_rsp_quiet"}, {oth_rdata[31:2], oth_valid, oth_err}, 32'd0);
        check({tag, ".other_rsp_rdata"}, oth_rdata, 32'd0);

        @(negedge clk_i);
        iomem_ready_i = 1'b0;
        check({tag, ".rsp_pulse_end"}, {30'b0, i_rsp_valid_o, d_rsp_valid_o}, 32'd0);
        check({tag, ".idle_after"}, {30'b0, busy_o, iomem_valid_o}, 32'd0);
    endtask

    initial begin
        bit   exp_pat[6];
        bit   grants[6];
        bit   rsp_port[6];
        int   ngrant, nrsp, low_run;
        bit   seen_txn, prev_valid, killed_rsp;

        //           data  addr          wdata         wstrb delay rdata         exp_addr      exp_wdata     wstrb vcyc chk exp_rdata     err
        vecs[0] = '{1'b1, 32'h4000_0010, 32'h0,        4'h0, 16,   32'hDEAD_BEEF, 32'h4000_0010, 32'h0,        4'h0, 17,  1, 32'hDEAD_BEEF, 1'b0};
        vecs[1] = '{1'b0, 32'h3000_0000, 32'h0,        4'h0, 0,    32'h0000_0013, 32'h3000_0000, 32'h0,        4'h0, 1,   1, 32'h0000_0013, 1'b0};
        vecs[2] = '{1'b1, 32'h4000_0003, 32'h1122_3344, 4'h8, 2,   32'hA5A5_A5A5, 32'h4000_0000, 32'h1122_3344, 4'h8, 3,   0, 32'h0,        1'b0};
        vecs[3] = '{1'b1, 32'h3000_0008, 32'h0,        4'h0, -1,   32'h0,        32'h3000_0008, 32'h0,        4'h0, 64,  1, 32'h0,        1'b1};
        vecs[4] = '{1'b1, 32'h3000_0008, 32'h0,        4'h0, 63,   32'h600D_F00D, 32'h3000_0008, 32'h0,        4'h0, 64,  1, 32'h600D_F00D, 1'b0};
        vecs[5] = '{1'b0, 32'h1000_0006, 32'h0,        4'h0, 3,    32'h1234_5678, 32'h1000_0004, 32'h0,        4'h0, 4,   1, 32'h1234_5678, 1'b0};
        vecs[6] = '{1'b0, 32'h2000_000C, 32'h0,        4'h0, -1,   32'h0,        32'h2000_000C, 32'h0,        4'h0, 64,  1, 32'h0,        1'b1};

        exp_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset values
        repeat (3) @(negedge clk_i);
        check("rst.valid_busy", {30'b0, iomem_valid_o, busy_o}, 32'd0);
        check("rst.rsp", {28'b0, i_rsp_valid_o, i_rsp_err_o, d_rsp_valid_o, d_rsp_err_o}, 32'd0);
        check("rst.addr", iomem_addr_o, 32'd0);
        check("rst.wdata", iomem_wdata_o, 32'd0);
        check("rst.wstrb", {28'b0, iomem_wstrb_o}, 32'd0);
        rst_n = 1'b1;

        // Both ports held valid: data wins the first tie, then strict alternation.
        @(negedge clk_i);
        i_req_valid_i = 1'b1; i_addr_i = 32'h3000_0101;
        d_req_valid_i = 1'b1; d_addr_i = 32'h4000_0202; d_wdata_i = 32'h0; d_wstrb_i = 4'h0;
        ngrant = 0; nrsp = 0; low_run = 0; seen_txn = 1'b0; prev_valid = 1'b0;
        for (int c = 0; c < 100 && nrsp < 6; c++) begin
            if (c > 0) @(negedge clk_i);
            iomem_ready_i = 1'b0;
            #1;
            if (i_rsp_valid_o || d_rsp_valid_o) begin
                rsp_port[nrsp] = d_rsp_valid_o;
                check("arb.rsp_port", {31'b0, d_rsp_valid_o}, {31'b0, grants[nrsp]});
                nrsp++;
            end
            if (iomem_valid_o) begin
                if (!prev_valid && seen_txn)
                    check("arb.low_gap_ge2", {31'b0, (low_run >= 2)}, 32'd1);
                if (!prev_valid) begin
                    check("arb.bus_addr", iomem_addr_o,
                          grants[ngrant-1] ? 32'h4000_0200 : 32'h3000_0100);
                    check("arb.no_ready_busy", {30'b0, i_req_ready_o, d_req_ready_o}, 32'd0);
                end
                seen_txn = 1'b1;
                low_run = 0;
                iomem_ready_i = 1'b1;
                iomem_rdata_i = 32'h0;
            end else begin
                low_run++;
            end
            prev_valid = iomem_valid_o;
            if (ngrant < 6 && (i_req_ready_o || d_req_ready_o)) begin
                grants[ngrant] = d_req_ready_o;
                check("arb.grant_order", {31'b0, d_req_ready_o}, {31'b0, exp_pat[ngrant]});
                ngrant++;
                if (ngrant == 6) begin
                    @(posedge clk_i); #1;
                    i_req_valid_i = 1'b0; d_req_valid_i = 1'b0;
                end
            end
        end
        check("arb.grants_seen", ngrant, 6);
        check("arb.rsps_seen", nrsp, 6);
        i_req_valid_i = 1'b0; d_req_valid_i = 1'b0; iomem_ready_i = 1'b0;
        repeat (2) @(negedge clk_i);

        // Single-transaction vectors
        for (int k = 0; k < 7; k++)
            do_txn(vecs[k], $sformatf("vec%0d", k));

        // Reset in the middle of a BUS phase kills the transaction silently.
        @(negedge clk_i);
        d_req_valid_i = 1'b1; d_addr_i = 32'h5000_0004; d_wstrb_i = 4'h0;
        @(posedge clk_i); #1;
        d_req_valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("mrst.valid_before", {31'b0, iomem_valid_o}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk_i);
        check("mrst.valid_busy", {30'b0, iomem_valid_o, busy_o}, 32'd0);
        rst_n = 1'b1;
        killed_rsp = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (i_rsp_valid_o || d_rsp_valid_o || iomem_valid_o) killed_rsp = 1'b1;
        end
        check("mrst.no_rsp", {31'b0, killed_rsp}, 32'd0);
        do_txn(vecs[0], "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iomem_initiator_arbiter.md
Name: iomem_initiator_arbiter

Overview:
- Initiator (master) side of the iomem valid/ready bus.
- Arbitrates between an instruction-fetch port and a data load/store port, and drives one transaction at a time onto iomem.
- Returns read data or an error to the port that issued the request.
- A timeout counter terminates transactions to addresses where no responder ever asserts ready.

Parameters:
- TIMEOUT_CYCLES, 64, maximum number of BUS-state cycles without ready before the transaction is aborted; legal range ≥ 2.
- CNT_W, 7, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- i_req_valid_i  in  1  fetch request pending; held until accepted
- i_req_ready_o  out  1  fetch request accepted this cycle
- i_addr_i  in  32  fetch byte address
- i_rsp_valid_o  out  1  fetch response, 1-cycle pulse
- i_rsp_rdata_o  out  32  fetch read data
- i_rsp_err_o  out  1  fetch timed out
- d_req_valid_i  in  1  data request pending; held until accepted
- d_req_ready_o  out  1  data request accepted this cycle
- d_addr_i  in  32  data byte address
- d_wdata_i  in  32  store data
- d_wstrb_i  in  4  byte strobes; 0 = load
- d_rsp_valid_o  out  1  data response, 1-cycle pulse
- d_rsp_rdata_o  out  32  load data
- d_rsp_err_o  out  1  data timed out
- iomem_valid_o  out  1  bus request valid
- iomem_ready_i  in  1  bus responder ready
- iomem_addr_o  out  32  bus address, word aligned
- iomem_wdata_o  out  32  bus write data
- iomem_wstrb_o  out  4  bus write strobes
- iomem_rdata_i  in  32  bus read data, valid when valid&ready
- busy_o  out  1  high in any state except IDLE

Behaviour:
- States:
  - IDLE: no transaction in progress.
  - BUS: transaction driven on iomem.
  - RESP: response delivered to the requester.
- Reset values (rst_n low at clk_i edge):
  - State = IDLE; iomem_valid_o, both *_req_ready_o, both *_rsp_valid_o, *_rsp_err_o and busy_o = 0.
  - All address, data and strobe registers = 0; grant pointer = fetch-last, so data wins the first tie.
- IDLE:
  - req_ready is combinational: asserted for exactly one requester that has req_valid high.
  - If both requesters are pending, the one not granted last is chosen (round-robin). If only one is pending, it is granted.
  - At the clock edge the granted request is captured:
    - addr → {addr[31:2],2'b00}.
    - Fetch: wstrb forced to 0, wdata = 0.
    - Grant pointer and counter updated; counter = 0; next state BUS.
- BUS:
  - iomem_valid_o = 1; addr, wdata and wstrb come from registers and stay stable the whole state.
  - iomem_ready_i high at the edge: capture iomem_rdata_i (for stores, the captured value is don't-care but the capture is still performed), clear err, go to RESP.
  - Otherwise, when counter == TIMEOUT_CYCLES-1: rdata = 0, err = 1, go to RESP.
  - Otherwise the counter increments.
  - Ready in the same cycle as the timeout: ready wins, err = 0.
- RESP:
  - iomem_valid_o = 0.
  - The owner's rsp_valid = 1 for exactly one cycle, together with rdata and err.
  - The other port's rsp outputs stay 0.
  - Next state IDLE.
- Protocol guarantees:
  - iomem_valid_o is never deasserted before ready, except on timeout.
  - iomem_valid_o is low for at least 2 cycles (RESP, IDLE) between transactions.
  - Only one outstanding transaction at any time.
- Latency:
  - Accept at cycle T; iomem_valid_o high from T+1.
  - Ready sampled at cycle T+k (k ≥ 1) → rsp_valid at T+k+1.
  - Minimum 3 cycles from accept to the next possible accept.
- Requests arriving while busy_o is high see req_ready = 0 and must be held by the requester.
- Reset mid-transaction: the next edge returns to IDLE, iomem_valid_o drops, and no response is issued for the killed transaction.

Test Plan:
1. Data load to 0x4000_0010; responder asserts ready 16 cycles after valid with rdata 0xDEADBEEF → d_rsp_valid one pulse, rdata 0xDEADBEEF, err 0; iomem_addr/wstrb stable throughout the BUS state.
2. Fetch at 0x3000_0000; responder ready combinational in the same cycle as valid → iomem_valid high exactly 1 cycle, i_rsp_valid 2 cycles after accept, rdata = responder value.
3. Store to 0x4000_0003, wstrb 4'b1000, wdata 0x11223344 → iomem_addr 0x4000_0000, wstrb 1000, wdata 0x11223344; d_rsp_valid pulse, err 0.
4. Fetch and data held valid continuously for 6 transactions → grants alternate D,I,D,I,D,I; ≥2 low cycles of iomem_valid between transactions.
5. Load to 0x3000_0008 with ready never asserted → iomem_valid high 64 cycles, then d_rsp_valid with err 1, rdata 0; ready asserted exactly on cycle 64 → err 0.
6. rst_n pulled low at BUS cycle 5 → iomem_valid 0 after that edge, no rsp_valid, busy_o 0; a fresh request afterwards completes normally.
